ysyx_23060025_csr_ctrl: RTL and testbench

CSR-access initiator sitting between the EXU and the CSR register file. It accepts one CSR/trap request per handshake and sequences reads and writes on the CSR file's single read port and single write port. Supported requests: CSRRW/CSRRS/CSRRC read-modify-write, ECALL (mepc, mcause, then mtvec fetch) and MRET (mepc fetch). It returns rd data and a PC redirect to the pipeline through a valid/ready response.

---
 rtl/ysyx_23060025_csr_pkg.sv | 51 +++++
 rtl/ysyx_23060025_csr_alu.sv | 36 +++
 rtl/ysyx_23060025_csr_ctrl.sv | 158 +++++++++++++++
 tb/tb_ysyx_23060025_csr_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060025_csr_pkg.sv
// Shared encodings for the CSR-access initiator: opcodes, CSR addresses, FSM states.
// Used by ysyx_23060025_csr_ctrl and ysyx_23060025_csr_alu.
package ysyx_23060025_csr_pkg;

   localparam int unsigned OP_W       = 3;
   localparam int unsigned CSR_ADDR_W = 12;
   localparam int unsigned STATE_W    = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NONE  = 3'b000,
      OP_CSRRW = 3'b001,
      OP_CSRRS = 3'b010,
      OP_CSRRC = 3'b011,
      OP_ECALL = 3'b101,
      OP_MRET  = 3'b110
   } op_e;

   localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
   localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC     = 12'h305;
   localparam logic [CSR_ADDR_W-1:0] CSR_MEPC      = 12'h341;
   localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
   localparam logic [CSR_ADDR_W-1:0] CSR_MVENDORID = 12'hF11;
   localparam logic [CSR_ADDR_W-1:0] CSR_MARCHID   = 12'hF12;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_RMW   = 3'd1,
      ST_EPC   = 3'd2,
      ST_CAUSE = 3'd3,
      ST_VEC   = 3'd4,
      ST_RET   = 3'd5,
      ST_RESP  = 3'd6
   } state_e;

   // Width-independent part of a latched request
   typedef struct packed {
      op_e                   op;
      logic [CSR_ADDR_W-1:0] addr;
      logic                  src_zero;
   } req_t;

   function automatic logic csr_implemented(input logic [CSR_ADDR_W-1:0] addr);
      return addr inside {CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE,
                          CSR_MVENDORID, CSR_MARCHID};
   endfunction

   function automatic logic csr_read_only(input logic [CSR_ADDR_W-1:0] addr);
      return addr inside {CSR_MVENDORID, CSR_MARCHID};
   endfunction

endpackage

// File: rtl/ysyx_23060025_csr_alu.sv
// Read-modify-write value for CSRRW/CSRRS/CSRRC and the write-suppress decision
// (set/clear with a zero source must not write).
module ysyx_23060025_csr_alu
   import ysyx_23060025_csr_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  op_e                   op,
   input  logic [DATA_WIDTH-1:0] old_val,
   input  logic [DATA_WIDTH-1:0] src,
   input  logic                  src_zero,
   output logic [DATA_WIDTH-1:0] new_val_c,
   output logic                  wen_c
);

   always_comb begin
      new_val_c = '0;
      wen_c     = 1'b0;
      case (op)
         OP_CSRRW: begin
            new_val_c = src;
            wen_c     = 1'b1;
         end
         OP_CSRRS: begin
            new_val_c = old_val | src;
            wen_c     = !src_zero;
         end
         OP_CSRRC: begin
            new_val_c = old_val & ~src;
            wen_c     = !src_zero;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ysyx_23060025_csr_ctrl.sv
// CSR-access initiator: sequences CSR RMW, ECALL and MRET on a 1R/1W CSR file.
// Optional macro CSR_ILLEGAL_CHK_EN enables unimplemented/read-only address checking.
module ysyx_23060025_csr_ctrl
   import ysyx_23060025_csr_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ECALL_CAUSE = 11
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OP_W-1:0]       in_op,
   input  logic [CSR_ADDR_W-1:0] in_csr_addr,
   input  logic [DATA_WIDTH-1:0] in_src,
   input  logic                  in_src_zero,
   input  logic [DATA_WIDTH-1:0] in_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_rd_data,
   output logic                  out_redirect,
   output logic [DATA_WIDTH-1:0] out_target,
   output logic                  out_illegal,
   output logic [CSR_ADDR_W-1:0] csr_raddr,
   input  logic [DATA_WIDTH-1:0] csr_rdata,
   output logic [CSR_ADDR_W-1:0] csr_waddr,
   output logic [DATA_WIDTH-1:0] csr_wdata,
   output logic                  csr_wen
);

   state_e                state;
   req_t                  req;
   logic [DATA_WIDTH-1:0] src_q;
   logic [DATA_WIDTH-1:0] pc_q;

   logic [DATA_WIDTH-1:0] alu_new_c;
   logic                  alu_wen_c;
   logic [DATA_WIDTH-1:0] rd_c;
   logic                  illegal_c;

   assign in_ready = (state == ST_IDLE);

   ysyx_23060025_csr_alu #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_alu (
      .op        (req.op),
      .old_val   (csr_rdata),
      .src       (src_q),
      .src_zero  (req.src_zero),
      .new_val_c (alu_new_c),
      .wen_c     (alu_wen_c)
   );

   // CSR file port drive; reads are combinational so these follow the state directly
   always_comb begin
      csr_raddr = '0;
      csr_waddr = '0;
      csr_wdata = '0;
      csr_wen   = 1'b0;
      rd_c      = csr_rdata;
      illegal_c = 1'b0;
      case (state)
         ST_RMW: begin
            csr_raddr = req.addr;
            csr_waddr = req.addr;
            csr_wdata = alu_new_c;
            csr_wen   = alu_wen_c;
`ifdef CSR_ILLEGAL_CHK_EN
            if (!csr_implemented(req.addr)) begin
               illegal_c = 1'b1;
               csr_wen   = 1'b0;
               rd_c      = '0;
            end else if (alu_wen_c && csr_read_only(req.addr)) begin
               illegal_c = 1'b1;
               csr_wen   = 1'b0;
            end
`else
            illegal_c = 1'b0;
`endif
         end
         ST_EPC: begin
            csr_waddr = CSR_MEPC;
            csr_wdata = pc_q;
            csr_wen   = 1'b1;
         end
         ST_CAUSE: begin
            csr_waddr = CSR_MCAUSE;
            csr_wdata = DATA_WIDTH'(ECALL_CAUSE);
            csr_wen   = 1'b1;
         end
         ST_VEC: csr_raddr = CSR_MTVEC;
         ST_RET: csr_raddr = CSR_MEPC;
         default: ;
      endcase
   end

   // Sequencer with registered response
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         req          <= '0;
         src_q        <= '0;
         pc_q         <= '0;
         out_valid    <= 1'b0;
         out_rd_data  <= '0;
         out_redirect <= 1'b0;
         out_target   <= '0;
         out_illegal  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  req.op       <= op_e'(in_op);
                  req.addr     <= in_csr_addr;
                  req.src_zero <= in_src_zero;
                  src_q        <= in_src;
                  pc_q         <= in_pc;
                  out_rd_data  <= '0;
                  out_target   <= '0;
                  out_redirect <= 1'b0;
                  out_illegal  <= 1'b0;
                  case (op_e'(in_op))
                     OP_CSRRW, OP_CSRRS, OP_CSRRC: state <= ST_RMW;
                     OP_ECALL: state <= ST_EPC;
                     OP_MRET:  state <= ST_RET;
                     default: begin
                        state     <= ST_RESP;
                        out_valid <= 1'b1;
                     end
                  endcase
               end
            end
            ST_RMW: begin
               out_rd_data <= rd_c;
               out_illegal <= illegal_c;
               out_valid   <= 1'b1;
               state       <= ST_RESP;
            end
            ST_EPC:   state <= ST_CAUSE;
            ST_CAUSE: state <= ST_VEC;
            ST_VEC, ST_RET: begin
               out_target   <= csr_rdata;
               out_redirect <= 1'b1;
               out_valid    <= 1'b1;
               state        <= ST_RESP;
            end
            ST_RESP: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060025_csr_ctrl.sv
// Bench for ysyx_23060025_csr_ctrl: directed scenarios then random requests against a
// request-level reference model. Honours CSR_ILLEGAL_CHK_EN like the design.
module tb_ysyx_23060025_csr_ctrl;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [11:0] in_csr_addr;
   logic [31:0] in_src;
   logic        in_src_zero;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rd_data;
   logic        out_redirect;
   logic [31:0] out_target;
   logic        out_illegal;
   logic [11:0] csr_raddr;
   logic [31:0] csr_rdata;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic        csr_wen;

   int nvec = 0;
   int nerr = 0;

   // CSR file seen by the DUT, and the model's expected contents
   logic [31:0] csr_mem [0:4095];
   logic [31:0] ref_csr [0:4095];
   logic [11:0] pool [7] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12, 12'h7C0};

   ysyx_23060025_csr_ctrl #(.DATA_WIDTH(32), .ECALL_CAUSE(11)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_csr_addr(in_csr_addr), .in_src(in_src), .in_src_zero(in_src_zero), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd_data(out_rd_data),
      .out_redirect(out_redirect), .out_target(out_target), .out_illegal(out_illegal),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_waddr(csr_waddr),
      .csr_wdata(csr_wdata), .csr_wen(csr_wen)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   assign csr_rdata = csr_mem[csr_raddr];

   always @(posedge clock) begin
      if (csr_wen) csr_mem[csr_waddr] <= csr_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
      csr_mem[a] = v;
      ref_csr[a] = v;
   endtask

   function automatic bit known(input logic [11:0] a);
      return a inside {12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12};
   endfunction

   // One full request/response; called at a negedge while the DUT is idle
   task automatic do_req(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                         input logic zero, input logic [31:0] pc, input int hold);
      int          lat;
      logic [31:0] old, nv, exp_rd, exp_tgt;
      bit          exp_redir, exp_ill, w;
      logic        exp_wen [1:4];
      logic [11:0] exp_wa  [1:4];
      logic [31:0] exp_wd  [1:4];
      for (int i = 1; i <= 4; i++) begin
         exp_wen[i] = 1'b0; exp_wa[i] = '0; exp_wd[i] = '0;
      end
      exp_rd = '0; exp_tgt = '0; exp_redir = 1'b0; exp_ill = 1'b0;
      case (op)
         3'b001, 3'b010, 3'b011: begin
            lat = 2;
            old = ref_csr[addr];
            nv  = (op == 3'b001) ? src : (op == 3'b010) ? (old | src) : (old & ~src);
            w   = (op == 3'b001) || !zero;
            exp_rd = old;
`ifdef CSR_ILLEGAL_CHK_EN
            if (!known(addr)) begin
               exp_ill = 1'b1; w = 1'b0; exp_rd = '0;
            end else if (w && (addr == 12'hF11 || addr == 12'hF12)) begin
               exp_ill = 1'b1; w = 1'b0;
            end
`endif
            exp_wen[1] = w; exp_wa[1] = addr; exp_wd[1] = nv;
            if (w) ref_csr[addr] = nv;
         end
         3'b101: begin
            lat = 4;
            exp_wen[1] = 1'b1; exp_wa[1] = 12'h341; exp_wd[1] = pc;
            exp_wen[2] = 1'b1; exp_wa[2] = 12'h342; exp_wd[2] = 32'd11;
            ref_csr[12'h341] = pc;
            ref_csr[12'h342] = 32'd11;
            exp_tgt = ref_csr[12'h305]; exp_redir = 1'b1;
         end
         3'b110: begin
            lat = 2;
            exp_tgt = ref_csr[12'h341]; exp_redir = 1'b1;
         end
         default: lat = 1;
      endcase

      chk("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_op = op; in_csr_addr = addr;
      in_src = src; in_src_zero = zero; in_pc = pc;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clock);
         if (k == 1) in_valid = 1'b0;
         chk($sformatf("out_valid_c%0d_op%0d", k, op), 32'(out_valid), 32'(k == lat));
         chk($sformatf("csr_wen_c%0d_op%0d", k, op), 32'(csr_wen), 32'(exp_wen[k]));
         if (exp_wen[k]) begin
            chk($sformatf("csr_waddr_c%0d", k), 32'(csr_waddr), 32'(exp_wa[k]));
            chk($sformatf("csr_wdata_c%0d", k), csr_wdata, exp_wd[k]);
         end
      end
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) @(negedge clock);
         chk("resp_valid", 32'(out_valid), 32'd1);
         chk("resp_rd_data", out_rd_data, exp_rd);
         chk("resp_target", out_target, exp_tgt);
         chk("resp_redirect", 32'(out_redirect), 32'(exp_redir));
         chk("resp_illegal", 32'(out_illegal), 32'(exp_ill));
         chk("resp_in_ready", 32'(in_ready), 32'd0);
         chk("resp_csr_wen", 32'(csr_wen), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      chk("post_hs_valid", 32'(out_valid), 32'd0);
      chk("post_hs_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] epc_pc;
      reset = 1'b0; in_valid = 1'b0; in_op = '0; in_csr_addr = '0;
      in_src = '0; in_src_zero = 1'b0; in_pc = '0; out_ready = 1'b0;
      for (int i = 0; i < 4096; i++) set_csr(12'(i), 32'd0);
      for (int i = 0; i < 7; i++) set_csr(pool[i], $urandom);

      // Reset state
      @(negedge clock); @(negedge clock);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_csr_wen", 32'(csr_wen), 32'd0);
      chk("rst_rd_data", out_rd_data, 32'd0);
      reset = 1'b1;
      @(negedge clock);

      // CSRRW mtvec, then CSRRS mstatus with and without a zero source
      set_csr(12'h305, 32'd0);
      do_req(3'b001, 12'h305, 32'h8000_0100, 1'b0, 32'h0, 0);
      set_csr(12'h300, 32'h1800);
      do_req(3'b010, 12'h300, 32'h8, 1'b0, 32'h0, 1);
      set_csr(12'h300, 32'h1800);
      do_req(3'b010, 12'h300, 32'h0, 1'b1, 32'h0, 0);

      // ECALL picks up the mtvec written above; MRET with a stalled consumer
      do_req(3'b101, 12'h0, 32'h0, 1'b0, 32'h8000_0040, 0);
      set_csr(12'h341, 32'h8000_0044);
      do_req(3'b110, 12'h0, 32'h0, 1'b0, 32'h0, 3);

      // Reset while in CAUSE: mepc written, mcause not
      set_csr(12'h342, 32'h5A5A_0001);
      epc_pc = 32'h8000_0200;
      chk("rst2_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_op = 3'b101; in_pc = epc_pc;
      @(negedge clock);
      in_valid = 1'b0;
      chk("rst2_epc_wen", 32'(csr_wen), 32'd1);
      @(negedge clock);
      chk("rst2_cause_waddr", 32'(csr_waddr), 32'h342);
      reset = 1'b0;
      #1;
      ref_csr[12'h341] = epc_pc;
      chk("rst2_out_valid", 32'(out_valid), 32'd0);
      chk("rst2_csr_wen", 32'(csr_wen), 32'd0);
      chk("rst2_redirect", 32'(out_redirect), 32'd0);
      chk("rst2_target", out_target, 32'd0);
      chk("rst2_illegal", 32'(out_illegal), 32'd0);
      chk("rst2_waddr", 32'(csr_waddr), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      do_req(3'b011, 12'h300, 32'h0000_0800, 1'b0, 32'h0, 1);

`ifdef CSR_ILLEGAL_CHK_EN
      do_req(3'b001, 12'hF11, 32'h1234_5678, 1'b0, 32'h0, 0);
      do_req(3'b001, 12'h7C0, 32'h1234_5678, 1'b0, 32'h0, 0);
`endif

      // Random traffic
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 9))
            0, 1:    rop = 3'b001;
            2, 3:    rop = 3'b010;
            4, 5:    rop = 3'b011;
            6:       rop = 3'b101;
            7:       rop = 3'b110;
            8:       rop = 3'b000;
            default: rop = ($urandom_range(0, 1) == 0) ? 3'b100 : 3'b111;
         endcase
         do_req(rop, pool[$urandom_range(0, 6)], $urandom, ($urandom_range(0, 3) == 0),
                {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom_range(0, 2));
      end

      // CSR file contents must match the model
      for (int i = 0; i < 7; i++)
         chk($sformatf("final_csr_%h", pool[i]), csr_mem[pool[i]], ref_csr[pool[i]]);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
